// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder_3to8 (
  input  logic [2:0] i,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with bounded hold time and preempt pulse on timeout.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [IDX_W:0]   search;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Returns {found, index}; scans ptr+1 .. ptr+8 so ptr itself is the lowest priority.
  function automatic logic [IDX_W:0] rr_search(input logic [N_REQ-1:0] req_v,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req_v[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign search    = rr_search(req, last_ptr_q);
  assign win_found = search[IDX_W];
  assign win_idx   = search[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_ptr_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_vld_d = 1'b0;
        if (en && win_found) begin
          state_d    = ST_GRANT;
          gnt_vld_d  = 1'b1;
          gnt_idx_d  = win_idx;
          hold_cnt_d = '0;
          last_ptr_d = win_idx;
        end
      end
      ST_GRANT: begin
        if (!en) begin
          state_d   = ST_IDLE;
          gnt_vld_d = 1'b0;
        end else if (!req[gnt_idx_q]) begin
          if (win_found) begin
            gnt_idx_d  = win_idx;
            hold_cnt_d = '0;
            last_ptr_d = win_idx;
          end else begin
            state_d   = ST_IDLE;
            gnt_vld_d = 1'b0;
          end
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          // Holder is still requesting, so the search always finds someone.
          preempt_d  = 1'b1;
          gnt_idx_d  = win_idx;
          hold_cnt_d = '0;
          last_ptr_d = win_idx;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_idx = gnt_idx_q;
    gnt_vld = gnt_vld_q;
    preempt = preempt_q;
  end

  decoder_3to8 u_gnt_dec (
    .i  (gnt_idx_q),
    .en (gnt_vld_q),
    .y  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: one instance at MAX_HOLD=4, one at MAX_HOLD=1.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt,   gnt_h1;
  logic [2:0] idx,   idx_h1;
  logic       vld,   vld_h1;
  logic       pre,   pre_h1;

  int unsigned n_cmp;
  int unsigned n_err;

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (idx),
    .gnt_vld (vld),
    .preempt (pre)
  );

  rr_arbiter_8 #(.MAX_HOLD(1), .CNT_W(8)) u_dut_h1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt_h1),
    .gnt_idx (idx_h1),
    .gnt_vld (vld_h1),
    .preempt (pre_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_idx4 [9];
    logic       exp_pre4 [9];
    n_cmp = 0;
    n_err = 0;
    en    = 1'b0;
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    check_eq("reset_async_gnt", 32'(gnt), 32'h00);

    // 1. Reset then idle
    for (int c = 0; c < 2; c++) begin
      step();
      check_eq("rst_gnt", 32'(gnt), 32'h00);
      check_eq("rst_vld", 32'(vld), 32'h0);
      check_eq("rst_pre", 32'(pre), 32'h0);
      check_eq("rst_idx", 32'(idx), 32'h0);
    end
    rst_n = 1'b1;
    step();
    check_eq("idle_vld", 32'(vld), 32'h0);

    // 2. Single requester
    en  = 1'b1;
    req = 8'b0000_0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("single_gnt", 32'(gnt), 32'h04);
      check_eq("single_idx", 32'(idx), 32'h2);
      check_eq("single_vld", 32'(vld), 32'h1);
    end
    req = 8'h00;
    step();
    check_eq("single_drop_vld", 32'(vld), 32'h0);
    check_eq("single_drop_gnt", 32'(gnt), 32'h00);

    // 3. Pure rotation with MAX_HOLD=1
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq("rot_idx", 32'(idx_h1), 32'(c % 8));
      check_eq("rot_vld", 32'(vld_h1), 32'h1);
      check_eq("rot_gnt", 32'(gnt_h1), 32'(8'h01 << (c % 8)));
    end

    // 4. Timeout / preempt with MAX_HOLD=4
    do_reset();
    exp_idx4 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    exp_pre4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    req = 8'b0000_1001;
    for (int c = 0; c < 9; c++) begin
      step();
      check_eq("tmo_idx", 32'(idx), 32'(exp_idx4[c]));
      check_eq("tmo_pre", 32'(pre), 32'(exp_pre4[c]));
      check_eq("tmo_vld", 32'(vld), 32'h1);
    end

    // 5. Back-to-back release, then release coinciding with timeout
    do_reset();
    req = 8'h20;
    step();
    check_eq("b2b_first_idx", 32'(idx), 32'h5);
    req = 8'h02;
    step();
    check_eq("b2b_idx", 32'(idx), 32'h1);
    check_eq("b2b_vld", 32'(vld), 32'h1);
    check_eq("b2b_pre", 32'(pre), 32'h0);
    step();
    step();
    step();
    check_eq("b2b_hold_idx", 32'(idx), 32'h1);
    req = 8'h01;
    step();
    check_eq("rel_tmo_idx", 32'(idx), 32'h0);
    check_eq("rel_tmo_pre", 32'(pre), 32'h0);

    // 6. en withdrawal and async reset mid-grant
    do_reset();
    req = 8'h40;
    step();
    check_eq("en_grant_idx", 32'(idx), 32'h6);
    en = 1'b0;
    step();
    check_eq("en_off_gnt", 32'(gnt), 32'h00);
    check_eq("en_off_pre", 32'(pre), 32'h0);
    en  = 1'b1;
    req = 8'hC0;
    step();
    check_eq("en_on_idx", 32'(idx), 32'h7);
    check_eq("en_on_gnt", 32'(gnt), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_gnt", 32'(gnt), 32'h00);
    check_eq("async_rst_vld", 32'(vld), 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("post_rst_idx", 32'(idx), 32'h6);
    check_eq("post_rst_gnt", 32'(gnt), 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
